stream_sum_acc: RTL and testbench

- Parametrised successor of the combinational 32-bit two-operand adder.
- Accepts a stream of operands over a valid/ready handshake and accumulates them into one sum per packet.
- Emits the sum, the operand count and an overflow flag over a valid/ready output handshake.
- Sits between operand producers and consumers in the FHE-synthesised datapath; wrap or saturating arithmetic, signed or unsigned, selected at elaboration.

---
 rtl/stream_sum_acc.sv | 233 +++++++++++++++++++++++
 tb/tb_stream_sum_acc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sum_acc.sv
// -----------------------------------------------------------------------------
// stream_sum_acc
//
// Packet accumulator. Operands arrive one per accepted beat over a valid/ready
// handshake and are summed into a single result per packet. A packet ends on
// a beat with in_last set, or on the beat that brings the operand count up to
// MAX_LEN. The sum, the operand count and a sticky overflow flag are then
// offered over a valid/ready output handshake. Wrap or saturating arithmetic,
// and signed or unsigned interpretation, are fixed at elaboration.
//
// The block alternates between two states:
//   ACCUM : accepting operands     (in_ready = 1, out_valid = 0)
//   DONE  : presenting the result  (in_ready = 0, out_valid = 1)
// Both handshake outputs come from flops, so there is no combinational path
// from in_valid or out_ready to in_ready or out_valid.
//
// Parameters:
//   WIDTH    operand and sum width, 2..64
//   MAX_LEN  maximum operands per packet, 1..255
//   SATURATE 0 = wrap modulo 2^WIDTH, 1 = clamp on every addition
//   SIGNED   0 = unsigned operands, 1 = two's-complement signed operands
//   CNT_W    derived width of the operand count; leave at its default
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand valid
//   in_ready      block can accept an operand this cycle
//   in_data       operand
//   in_last       final operand of the packet (looked at on accepted beats only)
//   out_valid     result valid
//   out_ready     consumer accepts the result
//   out_data      packet sum
//   out_count     number of operands in the packet
//   out_overflow  at least one addition in the packet wrapped or clamped
// -----------------------------------------------------------------------------
module stream_sum_acc #(
    parameter int WIDTH    = 32,
    parameter int MAX_LEN  = 16,
    parameter bit SATURATE = 1'b0,
    parameter bit SIGNED   = 1'b0,
    parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturation bounds for each interpretation.
    localparam logic [WIDTH-1:0] U_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               in_ready_q;

    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_ovf_q;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic               accept;     // operand taken on this edge
    logic [CNT_W-1:0]   count_inc;  // count including the current beat
    logic               end_beat;   // accepted beat closes the packet
    logic               out_fire;   // result taken on this edge

    assign accept    = in_valid & in_ready_q;
    assign count_inc = count_q + CNT_ONE;
    assign end_beat  = accept & (in_last | (count_inc == MAX_CNT));
    assign out_fire  = (state_q == DONE) & out_ready;

    // -------------------------------------------------------------------------
    // One accumulation step: acc_q (+) in_data, evaluated at WIDTH+1 bits.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   sum_wrap;
    logic [WIDTH-1:0]   sat_bound;
    logic               step_ovf;
    logic [WIDTH-1:0]   step_result;

    // NOTE: every signal assigned in this block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch to hold it.
    always_comb begin
        sum_ext     = '0;
        sum_wrap    = '0;
        sat_bound   = U_MAX;
        step_ovf    = 1'b0;
        step_result = '0;

        if (SIGNED) begin
            // Sign-extend both operands so bit WIDTH is the true sign.
            sum_ext  = {acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data};
            sum_wrap = sum_ext[WIDTH-1:0];
            // Overflow: operands agree in sign, the truncated result does not.
            step_ovf = (acc_q[WIDTH-1] == in_data[WIDTH-1]) &&
                       (sum_wrap[WIDTH-1] != acc_q[WIDTH-1]);
            // Both operands share acc_q's sign when overflowing, so it picks
            // the direction of the clamp.
            sat_bound = acc_q[WIDTH-1] ? S_MIN : S_MAX;
        end else begin
            sum_ext   = {1'b0, acc_q} + {1'b0, in_data};
            sum_wrap  = sum_ext[WIDTH-1:0];
            step_ovf  = sum_ext[WIDTH];
            sat_bound = U_MAX;
        end

        // Clamping per step lets a later operand bring the sum back in range.
        if (SATURATE && step_ovf) begin
            step_result = sat_bound;
        end else begin
            step_result = sum_wrap;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: begin
                if (end_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM state register and registered in_ready
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            // Held low through reset; rises on the first edge afterwards.
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Follows the next state so in_ready rises the cycle after the
            // result is taken, never in the same cycle as out_ready.
            in_ready_q <= (state_d == ACCUM);
        end
    end

    // -------------------------------------------------------------------------
    // Running accumulator
    // -------------------------------------------------------------------------
    // NOTE: this is plain datapath, but it is reset anyway: a reset in the
    // middle of a packet must discard the partial sum, not carry it over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            acc_q   <= step_result;
            count_q <= count_inc;
            ovf_q   <= ovf_q | step_ovf;
        end else if (out_fire) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Result registers
    // -------------------------------------------------------------------------
    // Loaded from the closing beat directly, so the result is visible one
    // cycle after that beat. They keep their value after the handshake; only
    // the running accumulator is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (end_beat) begin
            out_data_q  <= step_result;
            out_count_q <= count_inc;
            out_ovf_q   <= ovf_q | step_ovf;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q == DONE);
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_stream_sum_acc.sv
// -----------------------------------------------------------------------------
// tb_stream_sum_acc
//
// Directed bench for stream_sum_acc. Four instances share clock and reset:
//   0 : defaults (WIDTH 32, MAX_LEN 16, unsigned wrap)
//   1 : WIDTH 8, unsigned wrap
//   2 : WIDTH 8, signed saturate
//   3 : WIDTH 32, MAX_LEN 4, unsigned wrap
// Each instance has its own handshake signals; all are driven and sampled on
// the falling clock edge, away from the rising edge the design uses.
// -----------------------------------------------------------------------------
module tb_stream_sum_acc;

    logic clk;
    logic rst_n;

    logic        in_valid     [4];
    logic        in_last      [4];
    logic        out_ready    [4];
    logic [31:0] in_data      [4];

    logic        in_ready     [4];
    logic        out_valid    [4];
    logic [31:0] out_data     [4];
    logic [4:0]  out_count    [4];
    logic        out_overflow [4];

    int checks;
    int errors;

    // Per-instance output wires at native widths.
    logic [31:0] od0, od3;
    logic [7:0]  od1, od2;
    logic [4:0]  oc0, oc1, oc2;
    logic [2:0]  oc3;
    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic        of0, of1, of2, of3;

    stream_sum_acc u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(ir0), .in_data(in_data[0]), .in_last(in_last[0]),
        .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0), .out_count(oc0),
        .out_overflow(of0)
    );

    stream_sum_acc #(.WIDTH(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(ir1), .in_data(in_data[1][7:0]), .in_last(in_last[1]),
        .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1), .out_count(oc1),
        .out_overflow(of1)
    );

    stream_sum_acc #(.WIDTH(8), .SATURATE(1'b1), .SIGNED(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(ir2), .in_data(in_data[2][7:0]), .in_last(in_last[2]),
        .out_valid(ov2), .out_ready(out_ready[2]), .out_data(od2), .out_count(oc2),
        .out_overflow(of2)
    );

    stream_sum_acc #(.MAX_LEN(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[3]), .in_ready(ir3), .in_data(in_data[3]), .in_last(in_last[3]),
        .out_valid(ov3), .out_ready(out_ready[3]), .out_data(od3), .out_count(oc3),
        .out_overflow(of3)
    );

    assign in_ready[0] = ir0;  assign out_valid[0] = ov0;  assign out_overflow[0] = of0;
    assign in_ready[1] = ir1;  assign out_valid[1] = ov1;  assign out_overflow[1] = of1;
    assign in_ready[2] = ir2;  assign out_valid[2] = ov2;  assign out_overflow[2] = of2;
    assign in_ready[3] = ir3;  assign out_valid[3] = ov3;  assign out_overflow[3] = of3;
    assign out_data[0] = od0;
    assign out_data[1] = {24'd0, od1};
    assign out_data[2] = {24'd0, od2};
    assign out_data[3] = od3;
    assign out_count[0] = oc0;
    assign out_count[1] = oc1;
    assign out_count[2] = oc2;
    assign out_count[3] = {2'd0, oc3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge. Presents one operand, waits (bounded) for
    // in_ready, lets the next rising edge take it, returns on the falling edge
    // after that.
    task automatic send_beat(input int k, input logic [31:0] d, input logic last);
        int budget;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = last;
        budget = 0;
        while (!in_ready[k] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("beat_ready[%0d]", k), {31'd0, in_ready[k]}, 32'd1);
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic check_result(input int k, input string tag, input logic [31:0] data,
                                input logic [31:0] cnt, input logic ovf);
        check({tag, "_valid"}, {31'd0, out_valid[k]}, 32'd1);
        check({tag, "_data"},  out_data[k], data);
        check({tag, "_count"}, {27'd0, out_count[k]}, cnt);
        check({tag, "_ovf"},   {31'd0, out_overflow[k]}, {31'd0, ovf});
        check({tag, "_ready_low"}, {31'd0, in_ready[k]}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_last[i]   = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
        end

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_valid[%0d]", i), {31'd0, out_valid[i]}, 32'd0);
            check($sformatf("rst_data[%0d]", i),  out_data[i], 32'd0);
            check($sformatf("rst_count[%0d]", i), {27'd0, out_count[i]}, 32'd0);
            check($sformatf("rst_ovf[%0d]", i),   {31'd0, out_overflow[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_rst_ready[%0d]", i), {31'd0, in_ready[i]}, 32'd1);
        end

        // ---------------- Basic packet 5+7+9 ----------------
        out_ready[0] = 1'b1;
        send_beat(0, 32'd5, 1'b0);
        check("basic_mid_valid", {31'd0, out_valid[0]}, 32'd0);
        send_beat(0, 32'd7, 1'b0);
        send_beat(0, 32'd9, 1'b1);
        check_result(0, "basic", 32'd21, 32'd3, 1'b0);
        @(negedge clk);
        check("basic_after_valid", {31'd0, out_valid[0]}, 32'd0);
        check("basic_after_ready", {31'd0, in_ready[0]}, 32'd1);
        check("basic_after_hold",  out_data[0], 32'd21);

        // ---------------- Unsigned wrap, WIDTH 8: 200+100 ----------------
        out_ready[1] = 1'b1;
        send_beat(1, 32'd200, 1'b0);
        send_beat(1, 32'd100, 1'b1);
        check_result(1, "uwrap", 32'd44, 32'd2, 1'b1);
        @(negedge clk);

        // ---------------- Signed saturate, WIDTH 8 ----------------
        out_ready[2] = 1'b1;
        // 100+100 clamps to 127, then -50 gives 77.
        send_beat(2, 32'd100, 1'b0);
        send_beat(2, 32'd100, 1'b0);
        send_beat(2, 32'h0000_00CE, 1'b1);
        check_result(2, "ssat_pos", 32'd77, 32'd3, 1'b1);
        @(negedge clk);
        // 10 + (-3) = 7, no overflow: sticky flag must have been cleared.
        send_beat(2, 32'd10, 1'b0);
        send_beat(2, 32'h0000_00FD, 1'b1);
        check_result(2, "ssat_clean", 32'd7, 32'd2, 1'b0);
        @(negedge clk);
        // -100 + -100 clamps to -128.
        send_beat(2, 32'h0000_009C, 1'b0);
        send_beat(2, 32'h0000_009C, 1'b1);
        check_result(2, "ssat_neg", 32'h0000_0080, 32'd2, 1'b1);
        @(negedge clk);

        // ---------------- MAX_LEN 4 termination + backpressure ----------------
        out_ready[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(3, 32'd1, 1'b0);
        end
        check_result(3, "maxlen", 32'd4, 32'd4, 1'b0);
        // Producer holds the fifth operand while the result is pending.
        in_valid[3] = 1'b1;
        in_data[3]  = 32'd1;
        in_last[3]  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid[%0d]", c), {31'd0, out_valid[3]}, 32'd1);
            check($sformatf("bp_data[%0d]", c),  out_data[3], 32'd4);
            check($sformatf("bp_count[%0d]", c), {27'd0, out_count[3]}, 32'd4);
            check($sformatf("bp_ready[%0d]", c), {31'd0, in_ready[3]}, 32'd0);
        end
        out_ready[3] = 1'b1;
        @(negedge clk);
        out_ready[3] = 1'b0;
        check("bp_after_valid", {31'd0, out_valid[3]}, 32'd0);
        check("bp_after_ready", {31'd0, in_ready[3]}, 32'd1);
        check("bp_after_data",  out_data[3], 32'd4);
        check("bp_after_count", {27'd0, out_count[3]}, 32'd4);
        // Remaining two beats form the next packet; count restarts from 0.
        send_beat(3, 32'd1, 1'b0);
        send_beat(3, 32'd1, 1'b1);
        check_result(3, "maxlen_next", 32'd2, 32'd2, 1'b0);

        // ---------------- Asynchronous reset ----------------
        // Instance 0 mid-packet, instance 3 holding a result.
        send_beat(0, 32'd10, 1'b0);
        send_beat(0, 32'd20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid3", {31'd0, out_valid[3]}, 32'd0);
        check("arst_data3",  out_data[3], 32'd0);
        check("arst_count3", {27'd0, out_count[3]}, 32'd0);
        check("arst_data0",  out_data[0], 32'd0);
        check("arst_count0", {27'd0, out_count[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready0", {31'd0, in_ready[0]}, 32'd1);
        send_beat(0, 32'd3, 1'b0);
        send_beat(0, 32'd4, 1'b1);
        check_result(0, "arst_pkt", 32'd7, 32'd2, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
